mkio_tx_sequencer: RTL and testbench

- Bus-controller-side message sequencer that drives one mkio_transmitter.
- Accepts a command word, decodes how many data words follow, and pulses the transmitter once per word: command word first (cd_send=1), then data words (cd_send=0) fetched from an external message buffer.
- Provides start/done/error handshakes to the upper-level BC scheduler and supports abort.

---
 rtl/mkio_tx_sequencer.sv | 167 ++++++++++++++++
 tb/tb_mkio_tx_sequencer.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mkio_tx_sequencer.sv
// rtl/mkio_tx_sequencer.sv - sequences command and data words into one mkio_transmitter
module mkio_tx_sequencer #(
  parameter int GAP_CYCLES   = 0,
  parameter int BUSY_TIMEOUT = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        tx_start,
  input  logic [15:0] tx_cmd,
  input  logic        tx_abort,
  output logic        tx_busy,
  output logic        tx_done,
  output logic        tx_error,
  output logic [5:0]  words_sent,
  output logic        buf_rd_en,
  output logic [4:0]  buf_rd_addr,
  input  logic [15:0] buf_rd_data,
  output logic        imp_send,
  output logic        cd_send,
  output logic [15:0] data_send,
  input  logic        busy_send
);

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_LOAD      = 3'd1;
  localparam logic [2:0] S_WAIT_BUSY = 3'd2;
  localparam logic [2:0] S_WAIT_DONE = 3'd3;
  localparam logic [2:0] S_GAP       = 3'd4;

  localparam int         TW      = (BUSY_TIMEOUT > 2) ? $clog2(BUSY_TIMEOUT) : 1;
  localparam logic [TW-1:0] TIMER_END = TW'(BUSY_TIMEOUT - 2);
  localparam logic [3:0] GAP_END = 4'(GAP_CYCLES - 1);

  logic [2:0]    state;
  logic [5:0]    remaining;
  logic [4:0]    index;
  logic [TW-1:0] timer;
  logic [3:0]    gap_cnt;
  logic [15:0]   prefetch;
  logic          rd_pending;
  logic          busy_q;
  logic          busy_idle;
  logic          load_next;

  // Number of data words that follow a command word.
  function automatic logic [5:0] decode_count(input logic [10:0] cmd);
    logic [4:0] sa;
    sa = cmd[9:5];
    if (cmd[10])
      decode_count = 6'd0;
    else if (sa == 5'd0 || sa == 5'd31)
      decode_count = {5'd0, cmd[4]};
    else if (cmd[4:0] == 5'd0)
      decode_count = 6'd32;
    else
      decode_count = {1'b0, cmd[4:0]};
  endfunction

  assign tx_busy = (state != S_IDLE) || busy_send;

  // The transmitter counts as idle only once busy_send has been low for two
  // samples, which also guarantees imp_send never overlaps busy_send.
  assign busy_idle = !busy_send && !busy_q;

  // Decide when the prefetched data word is handed to the transmitter.
  always_comb begin
    load_next = 1'b0;
    if (state == S_WAIT_DONE && busy_idle && remaining != 6'd0 && GAP_CYCLES == 0)
      load_next = 1'b1;
    if (state == S_GAP && gap_cnt == GAP_END)
      load_next = 1'b1;
  end

  // Message FSM, buffer prefetch and output pulses; abort overrides everything.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= S_IDLE;
      remaining   <= 6'd0;
      index       <= 5'd0;
      timer       <= '0;
      gap_cnt     <= 4'd0;
      prefetch    <= 16'd0;
      rd_pending  <= 1'b0;
      busy_q      <= 1'b0;
      imp_send    <= 1'b0;
      cd_send     <= 1'b0;
      data_send   <= 16'd0;
      tx_done     <= 1'b0;
      tx_error    <= 1'b0;
      buf_rd_en   <= 1'b0;
      buf_rd_addr <= 5'd0;
      words_sent  <= 6'd0;
    end else begin
      busy_q     <= busy_send;
      imp_send   <= 1'b0;
      buf_rd_en  <= 1'b0;
      tx_done    <= 1'b0;
      tx_error   <= 1'b0;
      rd_pending <= buf_rd_en;
      if (rd_pending)
        prefetch <= buf_rd_data;

      if (tx_abort && state != S_IDLE) begin
        state <= S_IDLE;
      end else begin
        case (state)
          S_IDLE: begin
            if (tx_start && !tx_abort) begin
              data_send  <= tx_cmd;
              cd_send    <= 1'b1;
              words_sent <= 6'd0;
              index      <= 5'd0;
              remaining  <= decode_count(tx_cmd[10:0]);
              imp_send   <= 1'b1;
              state      <= S_LOAD;
            end
          end
          S_LOAD: begin
            timer <= '0;
            state <= S_WAIT_BUSY;
          end
          S_WAIT_BUSY: begin
            if (busy_send) begin
              state <= S_WAIT_DONE;
              if (remaining != 6'd0) begin
                buf_rd_en   <= 1'b1;
                buf_rd_addr <= index;
              end
            end else if (timer == TIMER_END) begin
              tx_error <= 1'b1;
              state    <= S_IDLE;
            end else begin
              timer <= timer + TW'(1);
            end
          end
          S_WAIT_DONE: begin
            if (busy_idle) begin
              words_sent <= words_sent + 6'd1;
              if (remaining == 6'd0) begin
                tx_done <= 1'b1;
                state   <= S_IDLE;
              end else if (GAP_CYCLES != 0) begin
                gap_cnt <= 4'd0;
                state   <= S_GAP;
              end
            end
          end
          S_GAP: begin
            if (gap_cnt != GAP_END)
              gap_cnt <= gap_cnt + 4'd1;
          end
          default: state <= S_IDLE;
        endcase

        if (load_next) begin
          data_send <= prefetch;
          cd_send   <= 1'b0;
          index     <= index + 5'd1;
          remaining <= remaining - 6'd1;
          imp_send  <= 1'b1;
          state     <= S_LOAD;
        end
      end
    end
  end

endmodule

// File: tb/tb_mkio_tx_sequencer.sv
// tb/tb_mkio_tx_sequencer.sv - directed bench for mkio_tx_sequencer (gap 0 and gap 3 instances)
module tb_mkio_tx_sequencer;

  localparam int BUSY_LEN = 6;
  localparam int LOGN     = 128;

  typedef struct {
    logic [15:0] cmd;
    int          g;
    int          n;
  } vec_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        tx_start [2] = '{1'b0, 1'b0};
  logic [15:0] tx_cmd [2] = '{16'd0, 16'd0};
  logic        tx_abort [2] = '{1'b0, 1'b0};
  logic        tx_busy [2];
  logic        tx_done [2];
  logic        tx_error [2];
  logic [5:0]  words_sent [2];
  logic        buf_rd_en [2];
  logic [4:0]  buf_rd_addr [2];
  logic [15:0] buf_rd_data [2] = '{16'd0, 16'd0};
  logic        imp_send [2];
  logic        cd_send [2];
  logic [15:0] data_send [2];
  logic        busy_send [2] = '{1'b0, 1'b0};

  logic        dead [2] = '{1'b0, 1'b0};
  logic [15:0] mem [2][32];
  int          cyc = 0;
  int          busy_cnt [2] = '{0, 0};
  int          fall_cyc [2] = '{0, 0};
  logic        imp_s [2];
  logic        en_s [2];
  logic [4:0]  a_s [2];

  int          imp_n [2] = '{0, 0};
  int          rd_n [2] = '{0, 0};
  int          done_n [2] = '{0, 0};
  int          err_n [2] = '{0, 0};
  int          err_cyc [2] = '{0, 0};
  int          overlap_n = 0;
  logic        imp_cd_log [2][LOGN];
  logic [15:0] imp_data_log [2][LOGN];
  int          imp_cyc_log [2][LOGN];
  int          gap_log [2][LOGN];
  logic [4:0]  rd_log [2][LOGN];

  int checks = 0;
  int errors = 0;

  vec_t vecs [7];

  for (genvar g = 0; g < 2; g++) begin : g_dut
    mkio_tx_sequencer #(.GAP_CYCLES(g == 0 ? 0 : 3), .BUSY_TIMEOUT(4)) u_dut (
      .clk(clk), .reset(reset),
      .tx_start(tx_start[g]), .tx_cmd(tx_cmd[g]), .tx_abort(tx_abort[g]),
      .tx_busy(tx_busy[g]), .tx_done(tx_done[g]), .tx_error(tx_error[g]),
      .words_sent(words_sent[g]),
      .buf_rd_en(buf_rd_en[g]), .buf_rd_addr(buf_rd_addr[g]), .buf_rd_data(buf_rd_data[g]),
      .imp_send(imp_send[g]), .cd_send(cd_send[g]), .data_send(data_send[g]),
      .busy_send(busy_send[g])
    );
  end

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  // Transmitter and message-buffer models for both instances.
  always @(posedge clk) begin
    for (int g = 0; g < 2; g++) begin
      imp_s[g] = imp_send[g];
      en_s[g]  = buf_rd_en[g];
      a_s[g]   = buf_rd_addr[g];
    end
    #1;
    for (int g = 0; g < 2; g++) begin
      buf_rd_data[g] = en_s[g] ? mem[g][a_s[g]] : 16'hDEAD;
      if (busy_cnt[g] > 0) begin
        busy_cnt[g]--;
        if (busy_cnt[g] == 0) begin
          busy_send[g] = 1'b0;
          fall_cyc[g]  = cyc;
        end
      end
      if (imp_s[g] && !dead[g]) begin
        busy_send[g] = 1'b1;
        busy_cnt[g]  = BUSY_LEN;
      end
    end
  end

  // Output monitor: logs pulses, read addresses and spacing.
  always @(negedge clk) begin
    for (int g = 0; g < 2; g++) begin
      if (imp_send[g]) begin
        if (imp_n[g] < LOGN) begin
          imp_cd_log[g][imp_n[g]]   = cd_send[g];
          imp_data_log[g][imp_n[g]] = data_send[g];
          imp_cyc_log[g][imp_n[g]]  = cyc;
          gap_log[g][imp_n[g]]      = cyc - fall_cyc[g];
        end
        imp_n[g]++;
        if (busy_send[g]) overlap_n++;
      end
      if (buf_rd_en[g]) begin
        if (rd_n[g] < LOGN) rd_log[g][rd_n[g]] = buf_rd_addr[g];
        rd_n[g]++;
      end
      if (tx_done[g]) done_n[g]++;
      if (tx_error[g]) begin
        err_n[g]++;
        err_cyc[g] = cyc;
      end
    end
  end

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic wait_idle(input int g);
    int k;
    for (k = 0; k < 3000; k++) begin
      if (!tx_busy[g]) break;
      @(negedge clk);
    end
    check("idle_timeout", int'(k < 3000), 1);
    repeat (3) @(negedge clk);
  endtask

  task automatic start_msg(input int g, input logic [15:0] cmd);
    @(negedge clk);
    tx_cmd[g]   = cmd;
    tx_start[g] = 1'b1;
    @(negedge clk);
    tx_start[g] = 1'b0;
  endtask

  task automatic run_vec(input vec_t v);
    int g, bi, br, bd, be, np, nr;
    g  = v.g;
    bi = imp_n[g]; br = rd_n[g]; bd = done_n[g]; be = err_n[g];
    start_msg(g, v.cmd);
    wait_idle(g);
    check("imp_count", imp_n[g] - bi, v.n + 1);
    check("words_sent", int'(words_sent[g]), v.n + 1);
    check("done_count", done_n[g] - bd, 1);
    check("error_count", err_n[g] - be, 0);
    check("rd_count", rd_n[g] - br, v.n);
    np = imp_n[g] - bi;
    if (np > v.n + 1) np = v.n + 1;
    for (int p = 0; p < np; p++) begin
      check("cd", int'(imp_cd_log[g][bi + p]), (p == 0) ? 1 : 0);
      check("data", int'(imp_data_log[g][bi + p]), (p == 0) ? int'(v.cmd) : 32'hA000 + p);
      if (p > 0) check("gap", gap_log[g][bi + p], (g == 0) ? 2 : 5);
    end
    nr = rd_n[g] - br;
    if (nr > v.n) nr = v.n;
    for (int i = 0; i < nr; i++)
      check("rd_addr", int'(rd_log[g][br + i]), i);
  endtask

  initial begin
    int bi, br, bd, be, k;
    vec_t v;

    vecs[0] = '{16'h0823, 0, 3};
    vecs[1] = '{16'h0C23, 0, 0};
    vecs[2] = '{16'h0820, 0, 32};
    vecs[3] = '{16'h0811, 0, 1};
    vecs[4] = '{16'h0C11, 0, 0};
    vecs[5] = '{16'h0823, 1, 3};
    vecs[6] = '{16'h0811, 1, 1};

    for (int g = 0; g < 2; g++)
      for (int i = 0; i < 32; i++)
        mem[g][i] = 16'hA001 + 16'(i);

    repeat (3) @(negedge clk);
    for (int g = 0; g < 2; g++) begin
      check("rst_imp_send", int'(imp_send[g]), 0);
      check("rst_tx_busy", int'(tx_busy[g]), 0);
      check("rst_words_sent", int'(words_sent[g]), 0);
      check("rst_data_send", int'(data_send[g]), 0);
      check("rst_cd_send", int'(cd_send[g]), 0);
      check("rst_buf_rd_en", int'(buf_rd_en[g]), 0);
      check("rst_buf_rd_addr", int'(buf_rd_addr[g]), 0);
      check("rst_tx_done", int'(tx_done[g]), 0);
      check("rst_tx_error", int'(tx_error[g]), 0);
    end
    reset = 1'b0;
    repeat (2) @(negedge clk);

    for (int i = 0; i < 7; i++) run_vec(vecs[i]);

    // busy_send never rises: tx_error BUSY_TIMEOUT clocks after imp_send
    bi = imp_n[0]; br = rd_n[0]; bd = done_n[0]; be = err_n[0];
    dead[0] = 1'b1;
    start_msg(0, 16'h0823);
    wait_idle(0);
    dead[0] = 1'b0;
    check("to_error_count", err_n[0] - be, 1);
    check("to_done_count", done_n[0] - bd, 0);
    check("to_imp_count", imp_n[0] - bi, 1);
    check("to_rd_count", rd_n[0] - br, 0);
    check("to_latency", err_cyc[0] - imp_cyc_log[0][bi], 4);
    check("to_tx_busy", int'(tx_busy[0]), 0);

    // start together with abort in IDLE is ignored
    bi = imp_n[0];
    @(negedge clk);
    tx_cmd[0] = 16'h0823; tx_start[0] = 1'b1; tx_abort[0] = 1'b1;
    @(negedge clk);
    tx_start[0] = 1'b0; tx_abort[0] = 1'b0;
    repeat (5) @(negedge clk);
    check("sa_imp_count", imp_n[0] - bi, 0);
    check("sa_tx_busy", int'(tx_busy[0]), 0);

    // abort during 2nd data word; start while busy is ignored
    bi = imp_n[0]; br = rd_n[0]; bd = done_n[0]; be = err_n[0];
    start_msg(0, 16'h0823);
    for (k = 0; k < 200 && imp_n[0] - bi < 2; k++) @(negedge clk);
    tx_cmd[0] = 16'hFFFF; tx_start[0] = 1'b1;
    @(negedge clk);
    tx_start[0] = 1'b0;
    for (k = 0; k < 200 && imp_n[0] - bi < 3; k++) @(negedge clk);
    check("ab_reach_word3", int'(k < 200), 1);
    for (k = 0; k < 10 && !busy_send[0]; k++) @(negedge clk);
    tx_abort[0] = 1'b1;
    @(negedge clk);
    tx_abort[0] = 1'b0;
    check("ab_busy_held", int'(tx_busy[0]), 1);
    for (k = 0; k < 50 && busy_send[0]; k++) @(negedge clk);
    check("ab_busy_released", int'(tx_busy[0]), 0);
    repeat (20) @(negedge clk);
    check("ab_imp_count", imp_n[0] - bi, 3);
    check("ab_data2", int'(imp_data_log[0][bi + 2]), 32'hA002);
    check("ab_rd_count", rd_n[0] - br, 2);
    check("ab_done_count", done_n[0] - bd, 0);
    check("ab_error_count", err_n[0] - be, 0);
    check("ab_words_sent", int'(words_sent[0]), 2);

    v = '{16'h0C23, 0, 0};
    run_vec(v);

    check("imp_busy_overlap", overlap_n, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

endmodule
